// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges in-order WB writes with buffered
// out-of-order long-latency-unit results, stalling the pipe to avoid starving the queue.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic        pipe_fwb_en,
    input  logic [5:0]  pipe_rd_addr,
    input  logic [31:0] pipe_data,
    output logic        stall_pipe,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic        lu_fwb,
    input  logic [5:0]  lu_rd_addr,
    input  logic [31:0] lu_data,
    input  logic        chk_fp,
    input  logic [5:0]  chk_addr,
    output logic        chk_hit,
    output logic        rf_we,
    output logic        frf_we,
    output logic [5:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_Q    = 2'd2
    } grant_t;

    logic              fwb_mem_r  [DEPTH];
    logic [5:0]        rd_mem_r   [DEPTH];
    logic [31:0]       data_mem_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  starve_cnt_r;

    grant_t            grant_s;
    logic              pipe_req_s;
    logic              q_req_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;

    assign pipe_req_s = pipe_wb_en | pipe_fwb_en;
    assign q_req_s    = |valid_r;
    assign full_s     = &valid_r;
    assign lu_ready   = ~full_s;
    assign push_s     = lu_valid & ~full_s;
    assign pop_s      = (grant_s == GNT_Q);
    assign stall_pipe = pipe_req_s & pop_s;

    // Port grant: the queue wins when the pipe is idle, the queue is full, or it has starved.
    always_comb begin
        grant_s = GNT_IDLE;
        if (q_req_s && (!pipe_req_s || full_s || (starve_cnt_r == CNT_W'(STARVE_MAX)))) begin
            grant_s = GNT_Q;
        end else if (pipe_req_s) begin
            grant_s = GNT_PIPE;
        end else begin
            grant_s = GNT_IDLE;
        end
    end

    // Hazard query over entries already resident; a same-cycle push is not yet visible.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_hit = chk_hit | (valid_r[i] & (fwb_mem_r[i] == chk_fp) & (rd_mem_r[i] == chk_addr));
        end
    end

    // LU result FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fwb_mem_r[i]  <= 1'b0;
                rd_mem_r[i]   <= 6'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                fwb_mem_r[wr_ptr_r]  <= lu_fwb;
                rd_mem_r[wr_ptr_r]   <= lu_rd_addr;
                data_mem_r[wr_ptr_r] <= lu_data;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Starvation counter: counts consecutive lost grants while the queue holds data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= '0;
        end else if (q_req_s && !pop_s) begin
            if (starve_cnt_r != CNT_W'(STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end
        end else begin
            starve_cnt_r <= '0;
        end
    end

    // Registered write port; an int write to x0 still consumes its slot but is suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            frf_we   <= 1'b0;
            rf_waddr <= 6'd0;
            rf_wdata <= 32'd0;
        end else begin
            case (grant_s)
                GNT_PIPE: begin
                    rf_we    <= pipe_wb_en & (pipe_rd_addr != 6'd0);
                    frf_we   <= pipe_fwb_en;
                    rf_waddr <= pipe_rd_addr;
                    rf_wdata <= pipe_data;
                end
                GNT_Q: begin
                    rf_we    <= ~fwb_mem_r[rd_ptr_r] & (rd_mem_r[rd_ptr_r] != 6'd0);
                    frf_we   <= fwb_mem_r[rd_ptr_r];
                    rf_waddr <= rd_mem_r[rd_ptr_r];
                    rf_wdata <= data_mem_r[rd_ptr_r];
                end
                default: begin
                    rf_we  <= 1'b0;
                    frf_we <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_wb_port_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en, pipe_fwb_en;
    logic [5:0]  pipe_rd_addr;
    logic [31:0] pipe_data;
    logic        stall_pipe;
    logic        lu_valid, lu_ready, lu_fwb;
    logic [5:0]  lu_rd_addr;
    logic [31:0] lu_data;
    logic        chk_fp, chk_hit;
    logic [5:0]  chk_addr;
    logic        rf_we, frf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_wb_en(pipe_wb_en), .pipe_fwb_en(pipe_fwb_en),
        .pipe_rd_addr(pipe_rd_addr), .pipe_data(pipe_data),
        .stall_pipe(stall_pipe),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_fwb(lu_fwb),
        .lu_rd_addr(lu_rd_addr), .lu_data(lu_data),
        .chk_fp(chk_fp), .chk_addr(chk_addr), .chk_hit(chk_hit),
        .rf_we(rf_we), .frf_we(frf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fwb;
        logic [5:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic        m_we, m_fwe;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    int          n_pass, n_total, n_stall;
    logic        s_stall, s_hit, s_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_we = 1'b0; m_fwe = 1'b0; m_addr = 6'd0; m_data = 32'd0;
        s_stall = 1'b0;
    endtask

    task automatic set_pipe(input logic wb, input logic fwb, input logic [5:0] a, input logic [31:0] d);
        pipe_wb_en = wb; pipe_fwb_en = fwb; pipe_rd_addr = a; pipe_data = d;
    endtask

    task automatic set_lu(input logic v, input logic fwb, input logic [5:0] a, input logic [31:0] d);
        lu_valid = v; lu_fwb = fwb; lu_rd_addr = a; lu_data = d;
    endtask

    // One clock: inputs are already driven (just after a negedge).
    task automatic step();
        bit   qreq, preq, full, gq, exp_hit;
        int   sz;
        ent_t e;
        #1;
        sz   = mq.size();
        qreq = (sz > 0);
        preq = pipe_wb_en || pipe_fwb_en;
        full = (sz == DEPTH);
        gq   = qreq && (!preq || full || m_starve == STARVE_MAX);
        exp_hit = 1'b0;
        foreach (mq[i]) if (mq[i].fwb == chk_fp && mq[i].rd == chk_addr) exp_hit = 1'b1;
        s_stall = stall_pipe; s_hit = chk_hit; s_ready = lu_ready;
        check("stall_pipe", stall_pipe, preq && gq);
        check("lu_ready", lu_ready, !full);
        check("chk_hit", chk_hit, exp_hit);
        if (stall_pipe) n_stall++;
        @(posedge clk);
        if (gq) begin
            e = mq.pop_front();
            m_we = !e.fwb && e.rd != 6'd0; m_fwe = e.fwb; m_addr = e.rd; m_data = e.data;
        end else if (preq) begin
            m_we = pipe_wb_en && pipe_rd_addr != 6'd0; m_fwe = pipe_fwb_en;
            m_addr = pipe_rd_addr; m_data = pipe_data;
        end else begin
            m_we = 1'b0; m_fwe = 1'b0;
        end
        if (lu_valid && !full) mq.push_back('{lu_fwb, lu_rd_addr, lu_data});
        m_starve = (qreq && !gq) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
        #1;
        check("rf_we", rf_we, m_we);
        check("frf_we", frf_we, m_fwe);
        check("rf_waddr", rf_waddr, m_addr);
        check("rf_wdata", rf_wdata, m_data);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse taken mid-cycle, with immediate output checks.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check({tag, "_rf_we"}, rf_we, 1'b0);
        check({tag, "_frf_we"}, frf_we, 1'b0);
        check({tag, "_waddr"}, rf_waddr, 6'd0);
        check({tag, "_wdata"}, rf_wdata, 32'd0);
        check({tag, "_lu_ready"}, lu_ready, 1'b1);
        check({tag, "_chk_hit"}, chk_hit, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int pa, stall_at;
        n_pass = 0; n_total = 0; n_stall = 0;
        rst = 1'b1;
        set_pipe(1'b0, 1'b0, 6'd0, 32'd0);
        set_lu(1'b0, 1'b0, 6'd0, 32'd0);
        chk_fp = 1'b0; chk_addr = 6'd0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // LU result reaches the port two cycles after its push, pipe idle
        n_stall = 0;
        set_lu(1'b1, 1'b0, 6'd5, 32'hDEADBEEF);
        step();
        set_lu(1'b0, 1'b0, 6'd0, 32'd0);
        step();
        check("t2_rf_we", rf_we, 1'b1);
        check("t2_waddr", rf_waddr, 6'd5);
        check("t2_wdata", rf_wdata, 32'hDEADBEEF);
        check("t2_no_stall", n_stall, 0);

        // Pipe busy every cycle: one stall after STARVE_MAX losing cycles
        n_stall = 0; pa = 10; stall_at = -1;
        for (int c = 0; c < 10; c++) begin
            set_pipe(1'b1, 1'b0, 6'(pa), 32'hA000 + 32'(pa));
            set_lu(c == 0, 1'b0, 6'd7, 32'h77);
            step();
            if (s_stall) begin
                stall_at = c;
                check("t3_q_addr", rf_waddr, 6'd7);
            end else begin
                if (stall_at >= 0 && c == stall_at + 1) check("t3_pipe_after", rf_waddr, 6'(pa));
                pa++;
            end
        end
        check("t3_stall_count", n_stall, 1);
        check("t3_stall_cycle", stall_at, 5);

        // x0 int write suppressed; f0 FP write allowed
        set_lu(1'b0, 1'b0, 6'd0, 32'd0);
        set_pipe(1'b1, 1'b0, 6'd0, 32'h1234);
        step();
        check("t5_x0_we", rf_we, 1'b0);
        set_pipe(1'b0, 1'b1, 6'd0, 32'h5678);
        step();
        check("t5_f0_fwe", frf_we, 1'b1);
        check("t5_f0_addr", rf_waddr, 6'd0);

        // Hazard query against a queued FP entry
        set_pipe(1'b1, 1'b0, 6'd20, 32'h20);
        set_lu(1'b1, 1'b1, 6'd3, 32'hF3F3);
        chk_fp = 1'b1; chk_addr = 6'd3;
        step();
        check("t6_push_cycle", s_hit, 1'b0);
        set_lu(1'b0, 1'b0, 6'd0, 32'd0);
        step();
        check("t6_hit_fp", s_hit, 1'b1);
        chk_fp = 1'b0;
        step();
        check("t6_miss_int", s_hit, 1'b0);
        chk_fp = 1'b1;
        set_pipe(1'b0, 1'b0, 6'd0, 32'd0);
        step();
        check("t6_pop_cycle", s_hit, 1'b1);
        step();
        check("t6_after_pop", s_hit, 1'b0);

        // Fill the FIFO under a busy pipe, then push+pop together
        set_pipe(1'b1, 1'b0, 6'd21, 32'h21);
        set_lu(1'b1, 1'b0, 6'd8, 32'h8); step();
        set_lu(1'b1, 1'b0, 6'd9, 32'h9); step();
        set_lu(1'b1, 1'b0, 6'd10, 32'hA); step();
        check("t4_full_ready", s_ready, 1'b0);
        check("t4_full_stall", s_stall, 1'b1);
        set_lu(1'b0, 1'b0, 6'd0, 32'd0); step();
        set_pipe(1'b0, 1'b0, 6'd0, 32'd0);
        set_lu(1'b1, 1'b0, 6'd11, 32'hB); step();
        check("t4_pushpop_ready", s_ready, 1'b1);
        check("t4_pop9", rf_waddr, 6'd9);
        set_lu(1'b0, 1'b0, 6'd0, 32'd0); step();
        check("t4_pop11", rf_waddr, 6'd11);

        // Reset with two queued entries
        set_pipe(1'b1, 1'b0, 6'd22, 32'h22);
        set_lu(1'b1, 1'b0, 6'd12, 32'hC); step();
        set_lu(1'b1, 1'b1, 6'd13, 32'hD); step();
        set_lu(1'b0, 1'b0, 6'd0, 32'd0);
        chk_fp = 1'b1; chk_addr = 6'd13;
        #1 check("t1_prereset_hit", chk_hit, 1'b1);
        do_reset("t1");

        // Randomized traffic; the pipe re-presents a stalled request
        for (int i = 0; i < 3000; i++) begin
            if (!s_stall) begin
                set_pipe($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                         6'($urandom_range(0, 7)), $urandom);
            end
            set_lu($urandom_range(0, 2) == 0, 1'($urandom), 6'($urandom_range(0, 7)), $urandom);
            chk_fp = 1'($urandom);
            chk_addr = 6'($urandom_range(0, 7));
            if (i == 1500) do_reset("rand");
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
